// File: rtl/dma_intr_source_if.sv
// Bus bundle between the DMA-side interrupt source and its surroundings.
// master: the side producing completions, config writes and acknowledges.
// slave : the interrupt source itself.
interface dma_intr_source_if #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int CNT_W              = 8
);
  logic                          done;
  logic                          cfg_write;
  logic [C_M_AXI_DATA_WIDTH-1:0] cfg_data;
  logic                          INTR;
  logic                          ENTR;
  logic [CNT_W-1:0]              pending;
  logic                          overflow;
  logic                          busy;

  modport master (
    output done, cfg_write, cfg_data, ENTR,
    input  INTR, pending, overflow, busy
  );

  modport slave (
    input  done, cfg_write, cfg_data, ENTR,
    output INTR, pending, overflow, busy
  );
endinterface

// File: rtl/dma_intr_source.sv
// DMA-side interrupt generator.
// Counts completed buffers, coalesces them against a programmable threshold
// and holds a level request (INTR) until the controller acknowledges (ENTR).
// After each acknowledge INTR is forced low for HOLDOFF_CYC cycles so the
// controller's one-cycle gate cannot see a stale request.
// Optional feature macro: DMA_INTR_TIMEOUT_EN -- adds a coalescing timer that
// raises the request after TIMEOUT_CYC idle cycles with 0 < pending < threshold.
module dma_intr_source #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int CNT_W              = 8,
  parameter int HOLDOFF_CYC        = 2,
  parameter int TIMEOUT_CYC        = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  dma_intr_source_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             enable;
  logic             enable_nxt;
  logic [CNT_W-1:0] threshold;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic [3:0]       hcnt;
  logic             ack;
  logic             hold_done;
  logic             thr_hit;
  logic             tmo_fire;
  logic             sat_done;
  logic             ovf_clr;
  logic             unused_cfg;

  // Saturating increment of the pending-completion count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // A zero threshold would fire with nothing pending; store it as one.
  function automatic logic [CNT_W-1:0] thr_norm(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  assign ack        = (state == ASSERT) && bus.ENTR;
  assign hold_done  = (hcnt == 4'(HOLDOFF_CYC - 1));
  assign thr_hit    = enable && (pending >= threshold);
  // A disabling write withdraws the request on the same edge it lands.
  assign enable_nxt = bus.cfg_write ? bus.cfg_data[31] : enable;
  assign sat_done   = bus.done && !ack && (pending == '1);
  assign ovf_clr    = bus.cfg_write && bus.cfg_data[30];
  assign unused_cfg = ^bus.cfg_data[29:CNT_W];

`ifdef DMA_INTR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tcnt;
  logic             tmo_arm;

  assign tmo_arm  = (state == IDLE) && enable && (pending != '0) && (pending < threshold);
  assign tmo_fire = tmo_arm && (tcnt == TMO_W'(TIMEOUT_CYC - 1));

  // Coalescing timer: runs only while a partial batch waits in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (tmo_arm && !tmo_fire) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end
`else
  logic unused_tmo;

  assign tmo_fire   = 1'b0;
  assign unused_tmo = (TIMEOUT_CYC > 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; an acknowledge outranks a same-cycle disable.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (thr_hit || tmo_fire) begin
          state_nxt = ASSERT;
        end
      end
      ASSERT: begin
        if (bus.ENTR) begin
          state_nxt = HOLDOFF;
        end else if (!enable_nxt) begin
          state_nxt = IDLE;
        end
      end
      HOLDOFF: begin
        if (hold_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hold-off counter, cleared whenever not in HOLDOFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
    end else if ((state == HOLDOFF) && !hold_done) begin
      hcnt <= hcnt + 1'b1;
    end else begin
      hcnt <= '0;
    end
  end

  // Configuration register: enable and coalescing threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable    <= 1'b0;
      threshold <= CNT_W'(1);
    end else if (bus.cfg_write) begin
      enable    <= bus.cfg_data[31];
      threshold <= thr_norm(bus.cfg_data[CNT_W-1:0]);
    end
  end

  // Pending count: reloaded with the same-cycle done on acknowledge so it is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (ack) begin
      pending <= CNT_W'(bus.done);
    end else if (bus.done) begin
      pending <= sat_inc(pending);
    end
  end

  // Sticky overflow; a new saturated done outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else begin
      overflow <= (overflow && !ovf_clr) || sat_done;
    end
  end

  assign bus.INTR     = (state == ASSERT);
  assign bus.busy     = (state != IDLE);
  assign bus.pending  = pending;
  assign bus.overflow = overflow;

endmodule

// File: tb/tb_dma_intr_source.sv
// Self-checking bench for dma_intr_source with a transaction-level reference
// model (request flag, acknowledge timestamp, counts) and randomized traffic.
module tb_dma_intr_source;
  localparam int H    = 2;
  localparam int TMO  = 256;
  localparam int CW   = 8;
  localparam int DW   = 32;
  localparam int PMAX = 255;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dma_intr_source_if #(.C_M_AXI_DATA_WIDTH(DW), .CNT_W(CW)) bus ();

  dma_intr_source #(
    .C_M_AXI_DATA_WIDTH(DW),
    .CNT_W(CW),
    .HOLDOFF_CYC(H),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int cyc;
  int m_ack;
  int m_pend;
  int m_thr;
  int m_tq;
  bit m_intr;
  bit m_ovf;
  bit m_en;

  logic [CW+2:0] dvec;
  assign dvec = {bus.INTR, bus.busy, bus.overflow, bus.pending};

  function automatic void model_reset();
    cyc    = 0;
    m_ack  = -1000;
    m_pend = 0;
    m_thr  = 1;
    m_tq   = 0;
    m_intr = 0;
    m_ovf  = 0;
    m_en   = 0;
  endfunction

  function automatic bit m_busy();
    return m_intr || (cyc < m_ack + H);
  endfunction

  function automatic logic [CW+2:0] mvec();
    return {m_intr, m_busy(), m_ovf, CW'(m_pend)};
  endfunction

  // One clock edge of the reference behaviour.
  function automatic void model_step();
    bit d, w, e, nen, nintr, novf, fire;
    logic [31:0] wd;
    int nthr, npend;
    d  = bus.done;
    w  = bus.cfg_write;
    wd = bus.cfg_data;
    e  = bus.ENTR;
    cyc++;
    nen   = w ? wd[31] : m_en;
    nthr  = w ? ((wd[7:0] == 8'd0) ? 1 : int'(wd[7:0])) : m_thr;
    npend = m_pend;
    novf  = m_ovf;
    nintr = m_intr;
    if (w && wd[30]) novf = 0;
    if (m_intr && e) begin
      nintr = 0;
      m_ack = cyc;
      npend = d ? 1 : 0;
      m_tq  = 0;
    end else begin
      if (d) begin
        if (m_pend == PMAX) novf = 1;
        else npend = m_pend + 1;
      end
      if (m_intr) begin
        if (!nen) nintr = 0;
        m_tq = 0;
      end else if (cyc > m_ack + H) begin
        fire = m_en && (m_pend >= m_thr);
`ifdef DMA_INTR_TIMEOUT_EN
        if (!fire && m_en && m_pend > 0 && m_pend < m_thr) begin
          if (m_tq == TMO - 1) begin
            fire = 1;
            m_tq = 0;
          end else begin
            m_tq++;
          end
        end else begin
          m_tq = 0;
        end
`endif
        if (fire) nintr = 1;
      end else begin
        m_tq = 0;
      end
    end
    m_en   = nen;
    m_thr  = nthr;
    m_pend = npend;
    m_ovf  = novf;
    m_intr = nintr;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.done      = 1'b0;
    bus.cfg_write = 1'b0;
    bus.cfg_data  = '0;
    bus.ENTR      = 1'b0;
  endtask

  task automatic cfg(input bit en, input bit clr, input int thr);
    bus.cfg_write = 1'b1;
    bus.cfg_data  = {en, clr, 22'b0, 8'(thr)};
    tick();
    bus.cfg_write = 1'b0;
    bus.cfg_data  = '0;
  endtask

  task automatic pulse_done();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask

  task automatic ack_and_settle();
    bus.ENTR = 1'b1;
    tick();
    bus.ENTR = 1'b0;
    repeat (H) tick();
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (dvec !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want 0", dvec);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (dvec !== mvec()) begin
      n_bad++;
      $display("FAIL reset_idle: got %h want %h", dvec, mvec());
    end
  endtask

  task automatic test_latency();
    int k;
    cfg(1, 0, 1);
    pulse_done();
    n_cmp++;
    if (bus.pending !== 8'd1 || bus.INTR !== 1'b0) begin
      n_bad++;
      $display("FAIL lat_pending: got pend=%0d intr=%b want 1/0", bus.pending, bus.INTR);
    end
    tick();
    n_cmp++;
    if (bus.INTR !== 1'b1) begin
      n_bad++;
      $display("FAIL lat_intr: got %b want 1", bus.INTR);
    end
    repeat (2) tick();
    bus.ENTR = 1'b1;
    tick();
    bus.ENTR = 1'b0;
    n_cmp++;
    if (bus.INTR !== 1'b0 || bus.pending !== 8'd0 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL lat_ack: got intr=%b pend=%0d busy=%b want 0/0/1", bus.INTR, bus.pending, bus.busy);
    end
    k = 0;
    while (bus.busy === 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k != H) begin
      n_bad++;
      $display("FAIL lat_holdoff: got %0d cycles want %0d", k, H);
    end
    n_cmp++;
    if (dvec !== mvec()) begin
      n_bad++;
      $display("FAIL lat_model: got %h want %h", dvec, mvec());
    end
  endtask

  task automatic test_threshold();
    cfg(1, 0, 4);
    for (int i = 0; i < 3; i++) begin
      pulse_done();
      tick();
      n_cmp++;
      if (bus.INTR !== 1'b0) begin
        n_bad++;
        $display("FAIL thr_below: got %b want 0 after %0d dones", bus.INTR, i + 1);
      end
    end
    pulse_done();
    n_cmp++;
    if (bus.pending !== 8'd4 || bus.INTR !== 1'b0) begin
      n_bad++;
      $display("FAIL thr_fourth: got pend=%0d intr=%b want 4/0", bus.pending, bus.INTR);
    end
    tick();
    n_cmp++;
    if (bus.INTR !== 1'b1 || dvec !== mvec()) begin
      n_bad++;
      $display("FAIL thr_fire: got %h want intr=1 %h", dvec, mvec());
    end
    ack_and_settle();
  endtask

  task automatic test_back_to_back();
    cfg(1, 0, 1);
    pulse_done();
    tick();
    bus.ENTR = 1'b1;
    bus.done = 1'b1;
    tick();
    bus.ENTR = 1'b0;
    bus.done = 1'b0;
    n_cmp++;
    if (bus.pending !== 8'd1 || bus.INTR !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_reload: got pend=%0d intr=%b want 1/0", bus.pending, bus.INTR);
    end
    for (int i = 0; i < H; i++) begin
      tick();
      n_cmp++;
      if (bus.INTR !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_holdoff: got %b want 0 at cycle %0d", bus.INTR, i + 1);
      end
    end
    tick();
    n_cmp++;
    if (bus.INTR !== 1'b1 || dvec !== mvec()) begin
      n_bad++;
      $display("FAIL b2b_reassert: got %h want intr=1 %h", dvec, mvec());
    end
    ack_and_settle();
  endtask

  task automatic test_overflow();
    cfg(0, 0, 1);
    for (int i = 0; i < 255; i++) pulse_done();
    n_cmp++;
    if (bus.pending !== 8'd255 || bus.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_sat: got pend=%0d ovf=%b want 255/0", bus.pending, bus.overflow);
    end
    pulse_done();
    n_cmp++;
    if (bus.pending !== 8'd255 || bus.overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_set: got pend=%0d ovf=%b want 255/1", bus.pending, bus.overflow);
    end
    cfg(0, 1, 1);
    n_cmp++;
    if (bus.overflow !== 1'b0 || bus.pending !== 8'd255) begin
      n_bad++;
      $display("FAIL ovf_clear: got ovf=%b pend=%0d want 0/255", bus.overflow, bus.pending);
    end
    cfg(1, 0, 1);
    tick();
    n_cmp++;
    if (bus.INTR !== 1'b1 || dvec !== mvec()) begin
      n_bad++;
      $display("FAIL ovf_fire: got %h want %h", dvec, mvec());
    end
    ack_and_settle();
  endtask

  task automatic test_withdraw();
    cfg(1, 0, 1);
    pulse_done();
    tick();
    cfg(0, 0, 1);
    n_cmp++;
    if (bus.INTR !== 1'b0 || bus.pending !== 8'd1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_drop: got intr=%b pend=%0d busy=%b want 0/1/0", bus.INTR, bus.pending, bus.busy);
    end
    cfg(1, 0, 1);
    tick();
    n_cmp++;
    if (bus.INTR !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_reassert: got %b want 1", bus.INTR);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.INTR !== 1'b0 || bus.pending !== 8'd0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_async_reset: got intr=%b pend=%0d busy=%b want 0/0/0", bus.INTR, bus.pending, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_timeout();
    int first;
    cfg(1, 0, 8);
    pulse_done();
    first = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (bus.INTR === 1'b1 && first == 0) first = k;
    end
`ifdef DMA_INTR_TIMEOUT_EN
    n_cmp++;
    if (first != TMO) begin
      n_bad++;
      $display("FAIL tmo_fire: got first rise at %0d want %0d", first, TMO);
    end
`else
    n_cmp++;
    if (first != 0) begin
      n_bad++;
      $display("FAIL tmo_absent: got rise at %0d want none", first);
    end
`endif
    n_cmp++;
    if (dvec !== mvec()) begin
      n_bad++;
      $display("FAIL tmo_model: got %h want %h", dvec, mvec());
    end
    if (bus.INTR !== 1'b1) begin
      cfg(1, 0, 1);
      tick();
    end
    ack_and_settle();
  endtask

  task automatic test_random();
    logic [31:0] wd;
    for (int i = 0; i < 3000 && n_bad < 20; i++) begin
      bus.done      = ($urandom_range(0, 2) == 0);
      bus.ENTR      = ($urandom_range(0, 2) == 0);
      bus.cfg_write = ($urandom_range(0, 19) == 0);
      wd            = $urandom;
      wd[31]        = ($urandom_range(0, 7) != 0);
      wd[7:0]       = 8'($urandom_range(0, 4));
      bus.cfg_data  = wd;
      tick();
      n_cmp++;
      if (dvec !== mvec()) begin
        n_bad++;
        $display("FAIL rand_cycle%0d: got %h want %h", i, dvec, mvec());
      end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_threshold();
    test_back_to_back();
    test_overflow();
    test_withdraw();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
